// File: rtl/led_fade_controller.sv
// rtl/led_fade_controller.sv - shared fade sequencer driving per-LED sigma-delta modulators
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready drops for the apply cycle
//   cmd_mode              0=OFF, 1=GLOW, 2=CHASE, 3=ON
//   cmd_mask              LEDs enabled by the command
//   busy                  fade FSM is not idle
//   level                 current shared brightness level
//   LED                   modulated LED drive, 1 = lit
module led_fade_controller #(
    parameter int NUM_LEDS   = 4,
    parameter int PWM_BITS   = 4,
    parameter int STEP_DIV   = 19,
    parameter int HOLD_TICKS = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    input  logic [NUM_LEDS-1:0] cmd_mask,
    output logic                busy,
    output logic [PWM_BITS-1:0] level,
    output logic [NUM_LEDS-1:0] LED
);

    localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_GLOW  = 2'd1;
    localparam logic [1:0] MODE_CHASE = 2'd2;
    localparam logic [1:0] MODE_ON    = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DOWN = 2'd3;

    localparam logic [PWM_BITS-1:0] LVL_MAX   = '1;
    localparam logic [PWM_BITS-1:0] LVL_ONE   = PWM_BITS'(1);
    localparam logic [7:0]          HOLD_LAST = 8'(HOLD_TICKS - 1);

    logic [1:0]          mode_q, mode_d;
    logic [NUM_LEDS-1:0] mask_q, mask_d;
    logic                apply_q, apply_d;
    logic [1:0]          state_q, state_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [STEP_DIV-1:0] presc_q, presc_d;
    logic [7:0]          hold_q, hold_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [PWM_BITS:0]   acc_q [NUM_LEDS];
    logic [PWM_BITS:0]   acc_d [NUM_LEDS];
    logic [PWM_BITS-1:0] duty  [NUM_LEDS];
    logic                accept;
    logic                tick;

    function automatic logic [IDX_W-1:0] lowest_bit(input logic [NUM_LEDS-1:0] m);
        lowest_bit = '0;
        for (int i = NUM_LEDS - 1; i >= 0; i--) begin
            if (m[i]) lowest_bit = IDX_W'(i);
        end
    endfunction

    // Next set bit strictly above cur, wrapping to the lowest set bit.
    function automatic logic [IDX_W-1:0] next_bit(input logic [NUM_LEDS-1:0] m,
                                                  input logic [IDX_W-1:0]    cur);
        logic found;
        next_bit = lowest_bit(m);
        found    = 1'b0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (!found && (i > int'(cur)) && m[i]) begin
                next_bit = IDX_W'(i);
                found    = 1'b1;
            end
        end
    endfunction

    assign cmd_ready = ~apply_q;
    assign busy      = (state_q != ST_IDLE);
    assign level     = level_q;
    assign accept    = cmd_valid && !apply_q;
    assign tick      = &presc_q;

    always_comb begin
        mode_d  = mode_q;
        mask_d  = mask_q;
        apply_d = accept;
        state_d = state_q;
        level_d = level_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        presc_d = presc_q + 1'b1;

        if (accept) begin
            mode_d = cmd_mode;
            mask_d = cmd_mask;
        end

        if (apply_q) begin
            // Apply cycle: the new command fully replaces any fade in progress.
            presc_d = '0;
            level_d = '0;
            hold_d  = '0;
            idx_d   = lowest_bit(mask_q);
            if ((mask_q == '0) || (mode_q == MODE_OFF) || (mode_q == MODE_ON)) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_UP;
            end
        end else if (tick) begin
            case (state_q)
                ST_IDLE: level_d = '0;
                ST_UP: begin
                    if (level_q != LVL_MAX) level_d = level_q + 1'b1;
                    if (level_q >= LVL_MAX - 1'b1) begin
                        state_d = ST_HOLD;
                        hold_d  = '0;
                    end
                end
                ST_HOLD: begin
                    if (hold_q == HOLD_LAST) state_d = ST_DOWN;
                    else                     hold_d  = hold_q + 1'b1;
                end
                ST_DOWN: begin
                    if (level_q != '0) level_d = level_q - 1'b1;
                    if (level_q <= LVL_ONE) begin
                        state_d = ST_UP;
                        if (mode_q == MODE_CHASE) idx_d = next_bit(mask_q, idx_q);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        LED = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            duty[i] = '0;
            case (mode_q)
                MODE_GLOW:  if (mask_q[i]) duty[i] = level_q;
                MODE_CHASE: if (idx_q == IDX_W'(i)) duty[i] = level_q;
                default:    duty[i] = '0;
            endcase
            acc_d[i] = apply_q ? '0
                     : ({1'b0, acc_q[i][PWM_BITS-1:0]} + {1'b0, duty[i]});
            // Gating by duty suppresses a stale carry left from a previous level.
            LED[i] = (mode_q == MODE_ON) ? mask_q[i]
                   : ((duty[i] != '0) && acc_q[i][PWM_BITS]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q  <= MODE_OFF;
            mask_q  <= '0;
            apply_q <= 1'b0;
            state_q <= ST_IDLE;
            level_q <= '0;
            presc_q <= '0;
            hold_q  <= '0;
            idx_q   <= '0;
            for (int i = 0; i < NUM_LEDS; i++) acc_q[i] <= '0;
        end else begin
            mode_q  <= mode_d;
            mask_q  <= mask_d;
            apply_q <= apply_d;
            state_q <= state_d;
            level_q <= level_d;
            presc_q <= presc_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            for (int i = 0; i < NUM_LEDS; i++) acc_q[i] <= acc_d[i];
        end
    end

endmodule

// File: doc/led_fade_controller.md
Name: led_fade_controller

Overview:
Multi-channel LED brightness sequencer for the board status LEDs. Accepts mode commands over a valid/ready handshake. Runs a single fade state machine that ramps a shared brightness level up, holds it, and ramps it down. Drives up to NUM_LEDS outputs through per-channel first-order sigma-delta PWM modulators, either all masked LEDs together (glow) or one at a time in rotation (chase).

Parameters:
NUM_LEDS, 4, number of LED outputs (1..8)
PWM_BITS, 4, brightness level width; max level = 2^PWM_BITS-1
STEP_DIV, 19, prescaler width; one ramp tick every 2^STEP_DIV clocks
HOLD_TICKS, 16, ticks spent in HOLD at max level (1..255)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_mode  in  2  0=OFF, 1=GLOW, 2=CHASE, 3=ON
cmd_mask  in  NUM_LEDS  LEDs enabled by the command
busy  out  1  FSM not in IDLE
level  out  PWM_BITS  current shared brightness level
LED  out  NUM_LEDS  PWM-modulated LED drive, 1 = lit

Behaviour:
- Reset (async on reset_n low, released sync to clk): mode=OFF, mask=0, FSM=IDLE, level=0, prescaler=0, hold count=0, chase index=0, all sigma-delta accumulators=0, LED=0, busy=0, cmd_ready=1.
- Handshake: accept on rising clk with cmd_valid && cmd_ready. After accept, cmd_ready=0 for exactly 1 cycle (apply cycle), then 1. cmd_mode/cmd_mask are sampled only on accept. Valid without ready is held by the sender and not lost.
- Apply cycle: prescaler, level and hold count cleared. Chase index = lowest set bit of new mask. Accumulators cleared. FSM next state:
  - mask==0 or mode OFF -> IDLE
  - mode ON -> IDLE
  - GLOW/CHASE -> FADE_UP
- Prescaler: STEP_DIV-bit free-running counter, cleared on apply. tick=1 for one cycle when counter is all ones. Wraps to 0.
- FSM (advances only on tick):
  - IDLE: level=0; stays.
  - FADE_UP: level+1 per tick; at max level -> HOLD, hold count=0.
  - HOLD: hold count+1 per tick; when count reaches HOLD_TICKS-1 on a tick -> FADE_DOWN.
  - FADE_DOWN: level-1 per tick; on reaching 0 -> FADE_UP. In CHASE, the chase index advances on this same cycle to the next set mask bit above the current one, wrapping to the lowest set bit. A single set bit keeps the same index.
  - level never wraps: saturates at 0 and max.
- busy = (FSM != IDLE).
- Per-channel duty:
  - OFF: 0
  - GLOW: level if mask bit set, else 0
  - CHASE: level only for the channel at chase index, else 0
  - ON: handled by override (see LED rule)
- Sigma-delta per channel: acc is (PWM_BITS+1) bits; acc <= acc[PWM_BITS-1:0] + duty each clk; modulator output = acc[PWM_BITS] (registered).
- LED rule:
  - ON mode: LED[i] = mask[i], forced, bypasses modulator.
  - duty==0: LED[i]=0 with no residual pulses.
  - Otherwise LED[i] = modulator output.
- Mid-operation command: the new command fully preempts. No completion of the current fade.
- Reset mid-fade: all state returns to reset values immediately; LED=0 while reset_n is low.
- Average LED on-fraction over 2^PWM_BITS cycles = duty/2^PWM_BITS, exact.

Test Plan:
1. Use STEP_DIV=2, HOLD_TICKS=2, PWM_BITS=4. Reset, then cmd GLOW mask=4'b0101 -> cmd_ready low 1 cycle; busy=1. level goes 0..15 in steps every 4 clocks, holds 8 clocks, then 15..0. LED[1]=LED[3]=0 throughout.
2. Hold duty=8 (freeze at level 8 by observation window) -> LED[0] toggles exactly 8 highs per 16 clocks. At level 0, LED stays 0.
3. CHASE mask=4'b1011 -> active channel sequence 0,1,3,0,… advancing at each FADE_DOWN->FADE_UP transition. Non-active LEDs stay 0.
4. ON mask=4'b0110 -> LED=4'b0110 the cycle after apply, busy=0. Then OFF -> LED=0, level=0.
5. GLOW with mask=0 -> FSM IDLE, busy=0, LED=0. cmd_valid held while cmd_ready=0 -> command accepted the following cycle, not dropped.
6. Assert reset_n low mid FADE_UP at level 9 -> LED=0, level=0, busy=0, cmd_ready=1 asynchronously. After release, behaves as fresh reset.
